// File: rtl/opsel_mux_pipe_if.sv
// Handshake and data bundle between the functional units and the result/status stage.
// The slave modport is the opsel_mux_pipe side; master is the producer/consumer side.
interface opsel_mux_pipe_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 16,
  parameter int SELW  = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      opcode;
  logic [NCH*WIDTH-1:0] channels;
  logic                 err_ovf;
  logic                 err_dbz_div;
  logic                 err_dbz_mod;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [NCH-1:0]       hotselect;
  logic [2:0]           error_code;
  logic [2:0]           sticky_err;
  logic                 clr_err;

  modport slave (
    input  in_valid, opcode, channels, err_ovf, err_dbz_div, err_dbz_mod,
    input  out_ready, clr_err,
    output in_ready, out_valid, result, hotselect, error_code, sticky_err
  );

  modport master (
    output in_valid, opcode, channels, err_ovf, err_dbz_div, err_dbz_mod,
    output out_ready, clr_err,
    input  in_ready, out_valid, result, hotselect, error_code, sticky_err
  );
endinterface

// File: rtl/opsel_mux_pipe.sv
// Two-stage opcode decode / channel mux / error encoder with valid-ready flow control.
// S1 holds decoded select, raw channels and error code; S2 holds the muxed result.
module opsel_mux_pipe #(
  parameter int WIDTH    = 32,
  parameter int NCH      = 16,
  parameter int SELW     = 4,
  parameter bit ERR_ZERO = 1'b0
) (
  input logic             clk,
  input logic             rst,
  opsel_mux_pipe_if.slave bus
);

  logic                 s1_valid_q, s1_valid_d;
  logic [NCH-1:0]       s1_hot_q, s1_hot_d;
  logic [NCH*WIDTH-1:0] s1_data_q, s1_data_d;
  logic [2:0]           s1_err_q, s1_err_d;

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [NCH-1:0]       hot_q, hot_d;
  logic [2:0]           err_q, err_d;
  logic [2:0]           sticky_q, sticky_d;

  logic                 s2_adv;
  logic                 in_ready;
  logic                 deliver;
  logic [NCH-1:0]       dec_hot;
  logic [WIDTH-1:0]     mux_res;

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign deliver  = out_valid_q && bus.out_ready;

  // Opcodes at or above NCH match no channel, leaving an all-zero select.
  always_comb begin
    dec_hot = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (bus.opcode == SELW'(k)) dec_hot[k] = 1'b1;
    end
  end

  always_comb begin
    mux_res = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      mux_res = mux_res | ({WIDTH{s1_hot_q[k]}} & s1_data_q[k*WIDTH +: WIDTH]);
    end
    if (ERR_ZERO && (s1_err_q != 3'b000)) mux_res = '0;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_hot_d   = s1_hot_q;
    s1_data_d  = s1_data_q;
    s1_err_d   = s1_err_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_hot_d  = dec_hot;
        s1_data_d = bus.channels;
        s1_err_d  = {~|dec_hot, bus.err_ovf, bus.err_dbz_div | bus.err_dbz_mod};
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hot_d       = hot_q;
    err_d       = err_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = mux_res;
        hot_d    = s1_hot_q;
        err_d    = s1_err_q;
      end
    end
  end

  // A clear coinciding with a delivery keeps that delivery's code rather than zero.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.clr_err) sticky_d = deliver ? err_q : 3'b000;
    else if (deliver) sticky_d = sticky_q | err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_hot_q    <= '0;
      s1_data_q   <= '0;
      s1_err_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hot_q       <= '0;
      err_q       <= '0;
      sticky_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hot_q    <= s1_hot_d;
      s1_data_q   <= s1_data_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hot_q       <= hot_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.hotselect  = hot_q;
  assign bus.error_code = err_q;
  assign bus.sticky_err = sticky_q;

endmodule
